snap_capture_ctrl: RTL and testbench
====================================

Name: snap_capture_ctrl

Overview:
- Sequences a single-shot snapshot capture into a dual-port BRAM.
- Software arms the capture through a ppc2simulink control word. The block waits for a trigger, then writes DEPTH consecutive samples.
- It publishes a status word of done/busy flags and the write count. The status word is read back through an opb_register_simulink2ppc instance such as the snap addr register.
- Sits between the user datapath (for example the vacc output) and the snap BRAM plus its status register. All logic runs in the OPB_Clk domain.

Parameters:
- ADDR_WIDTH, 9, BRAM address width; DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, sample and BRAM data width.

Ports:
- OPB_Clk  in  1  clock for all logic.
- OPB_Rst  in  1  asynchronous, active-high reset.
- ctrl_in  in  32  control word from software.
  - bit0 arm: capture starts on a 0->1 edge.
  - bit1 trig_imm: 1 = trigger immediately on arm.
  - bit2 use_we: 1 = write only when we_in is high.
  - Other bits ignored.
- trig_in  in  1  external trigger, level-sampled each cycle.
- we_in  in  1  data-valid qualifier.
- din  in  DATA_WIDTH  sample data.
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_data  out  DATA_WIDTH  BRAM write data.
- bram_we  out  1  BRAM write enable.
- status_out  out  32  status word, drives user_data_in of the status register.
  - bit31 done.
  - bit30 busy (ARMED or CAPTURE).
  - bits[ADDR_WIDTH:0] wr_count, counting 0..DEPTH.
  - Other bits 0.

Behaviour:
- Reset (async, OPB_Rst=1): state=IDLE, arm_d=0, wr_count=0, bram_addr=0, bram_data=0, bram_we=0, status_out=0.
- Arm edge: arm_re = ctrl_in[0] & ~arm_d, where arm_d is registered each cycle. Only arm_re starts a capture; holding bit0 high does not re-arm.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: on arm_re -> ARMED, with wr_count cleared to 0 and done cleared.
  - ARMED: on arm_re -> stay ARMED (re-arm is a no-op). If trig_imm=1 or trig_in=1 -> CAPTURE.
  - CAPTURE: a write occurs when use_we=0, or when use_we=1 and we_in=1.
    - On a write: bram_we=1, bram_addr=wr_count[ADDR_WIDTH-1:0], bram_data=din, all registered. Outputs appear 1 cycle after the qualifying input cycle.
    - After a write, wr_count increments.
    - When wr_count reaches DEPTH -> DONE. Exactly DEPTH writes are made; bram_addr wraps to 0 but is never written again.
    - arm_re during CAPTURE restarts: wr_count=0, back to ARMED.
  - DONE: done=1, busy=0, bram_we=0. arm_re -> ARMED with done cleared and wr_count cleared.
- Trigger cycle: the cycle where ARMED sees the trigger is not captured. The first sample is din on the first cycle in CAPTURE.
- ctrl_in[2:1] are sampled live each cycle, not latched at arm.
- bram_we is deasserted on any cycle with no write; bram_addr and bram_data hold their last values.
- status_out is registered and updates the cycle after the state or count changes.
- Reset asserted mid-capture: immediate return to IDLE with all outputs 0. No partial done is reported.
- DEPTH boundary: wr_count is ADDR_WIDTH+1 bits, so DEPTH (for example 512 = 0x200) is representable in status_out.

Test Plan:
1. Reset, then arm with trig_imm=1, use_we=0, din = incrementing 0x100, 0x101, ...
   - Required: 512 writes with addr 0..511.
   - Required: addr 0 holds the first din after the CAPTURE entry cycle.
   - Required: status_out=0x80000200 after completion; bram_we=0 afterwards.
2. Arm with trig_imm=0, hold trig_in=0 for 50 cycles.
   - Required: status_out=0x40000000 and no bram_we.
   - Then pulse trig_in for 1 cycle. Required: capture completes, status=0x80000200.
3. use_we=1, we_in toggling every other cycle.
   - Required: exactly 512 writes spread over about 1024 cycles.
   - Required: addresses contiguous, data equal to din on cycles where we_in=1.
4. Hold ctrl_in[0]=1 through completion.
   - Required: no second capture.
   - Drop bit0 to 0, then raise it to 1. Required: a new capture; done clears and status=0x40000000 on the cycle after arm_re.
5. Re-arm mid-capture at wr_count=100.
   - Required: state ARMED, wr_count=0, then a full 512-write capture after the trigger.
6. Assert OPB_Rst asynchronously mid-capture at wr_count=300.
   - Required: outputs 0 immediately, without waiting for an OPB_Clk edge.
   - After release, no activity until a fresh arm edge.

Source files
------------

// File: rtl/snap_capture_ctrl.sv
// Single-shot snapshot sequencer: arm from software, wait for a trigger,
// then write DEPTH consecutive samples into the snap BRAM and publish status.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a rising edge on ctrl_in[0]
// S_ARMED   | armed, waiting for trig_imm or trig_in
// S_CAPTURE | writing qualified samples, wr_count tracks the next address
// S_DONE    | DEPTH samples written; done reported until re-armed
module snap_capture_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  OPB_Clk,
    input  logic                  OPB_Rst,
    input  logic [31:0]           ctrl_in,
    input  logic                  trig_in,
    input  logic                  we_in,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data,
    output logic                  bram_we,
    output logic [31:0]           status_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [ADDR_WIDTH:0] wr_count;
    logic [ADDR_WIDTH:0] cnt_nxt;
    logic                arm_d;
    logic                arm_re;
    logic                trig_imm;
    logic                use_we;
    logic                wr_en;
    logic [31:0]         status_nxt;
    logic                unused_ctrl;

    assign arm_re      = ctrl_in[0] & ~arm_d;
    assign trig_imm    = ctrl_in[1];
    assign use_we      = ctrl_in[2];
    assign unused_ctrl = ^ctrl_in[31:3];

    // A new arm edge wins over a trigger or a write in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wr_count;
        wr_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm_re) begin
                    state_nxt = S_ARMED;
                    cnt_nxt   = '0;
                end
            end
            S_ARMED: begin
                if (arm_re) begin
                    cnt_nxt = '0;
                end else if (trig_imm || trig_in) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (arm_re) begin
                    state_nxt = S_ARMED;
                    cnt_nxt   = '0;
                end else if (!use_we || we_in) begin
                    wr_en   = 1'b1;
                    cnt_nxt = wr_count + CNT_ONE;
                    if (cnt_nxt == DEPTH) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (arm_re) begin
                    state_nxt = S_ARMED;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status is built from the next-state values so it registers alongside the state.
    always_comb begin
        status_nxt                 = '0;
        status_nxt[31]             = (state_nxt == S_DONE);
        status_nxt[30]             = (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
        status_nxt[ADDR_WIDTH:0]   = cnt_nxt;
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state      <= S_IDLE;
            arm_d      <= 1'b0;
            wr_count   <= '0;
            bram_addr  <= '0;
            bram_data  <= '0;
            bram_we    <= 1'b0;
            status_out <= '0;
        end else begin
            state      <= state_nxt;
            arm_d      <= ctrl_in[0];
            wr_count   <= cnt_nxt;
            bram_we    <= wr_en;
            status_out <= status_nxt;
            if (wr_en) begin
                bram_addr <= wr_count[ADDR_WIDTH-1:0];
                bram_data <= din;
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Bench for snap_capture_ctrl: directed scenarios plus random traffic, every
// cycle compared against a capture-level reference model.
module tb_snap_capture_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          OPB_Clk = 1'b0;
    logic          OPB_Rst;
    logic [31:0]   ctrl_in;
    logic          trig_in;
    logic          we_in;
    logic [DW-1:0] din;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;
    logic [31:0]   status_out;

    snap_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .OPB_Clk    (OPB_Clk),
        .OPB_Rst    (OPB_Rst),
        .ctrl_in    (ctrl_in),
        .trig_in    (trig_in),
        .we_in      (we_in),
        .din        (din),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .bram_we    (bram_we),
        .status_out (status_out)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;
    bit din_inc = 1'b0;

    // Model: mode 0 idle, 1 waiting for trigger, 2 capturing, 3 finished.
    int            m_mode;
    int            m_cnt;
    bit            m_arm_prev;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_we;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s     = 32'(m_cnt);
        s[31] = (m_mode == 3);
        s[30] = (m_mode == 1) || (m_mode == 2);
        return s;
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_cnt      = 0;
        m_arm_prev = 1'b0;
        e_addr     = '0;
        e_data     = '0;
        e_we       = 1'b0;
    endtask

    task automatic model_edge();
        bit arm_edge;
        if (OPB_Rst) begin
            model_reset();
        end else begin
            arm_edge   = ctrl_in[0] && !m_arm_prev;
            m_arm_prev = ctrl_in[0];
            e_we       = 1'b0;
            if (arm_edge) begin
                m_mode = 1;
                m_cnt  = 0;
            end else if (m_mode == 1) begin
                if (ctrl_in[1] || trig_in) m_mode = 2;
            end else if (m_mode == 2 && (!ctrl_in[2] || we_in)) begin
                e_we   = 1'b1;
                e_addr = AW'(m_cnt % DEPTH);
                e_data = din;
                m_cnt++;
                if (m_cnt == DEPTH) m_mode = 3;
            end
        end
    endtask

    task automatic step();
        @(posedge OPB_Clk);
        model_edge();
        #1;
        chk("we", 64'(bram_we), 64'(e_we));
        chk("addr", 64'(bram_addr), 64'(e_addr));
        chk("data", 64'(bram_data), 64'(e_data));
        chk("status", 64'(status_out), 64'(exp_status()));
        if (bram_we) n_wr++;
        if (din_inc) din = din + 1;
        else         din = $urandom;
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                               input int max, input string tag);
        int i = 0;
        while (((status_out & mask) != val) && i < max) begin
            step();
            i++;
        end
        chk(tag, 64'(status_out & mask), 64'(val));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        OPB_Rst = 1'b1;
        ctrl_in = '0;
        trig_in = 1'b0;
        we_in   = 1'b0;
        din     = '0;
        model_reset();
        repeat (3) step();
        chk("rst_status", 64'(status_out), 64'h0);
        OPB_Rst = 1'b0;
        repeat (2) step();

        // 1: immediate trigger, no qualifier, incrementing data
        din_inc = 1'b1;
        din     = 32'h100;
        n_wr    = 0;
        ctrl_in = 32'h3;
        step();
        ctrl_in = 32'h2;
        step();
        step();
        // arm cycle saw 0x100, trigger cycle 0x101, first capture cycle 0x102
        chk("t1_first_addr", 64'(bram_addr), 64'h0);
        chk("t1_first_data", 64'(bram_data), 64'h102);
        wait_status(32'h8000_0000, 32'h8000_0000, 600, "t1_done");
        chk("t1_writes", 64'(n_wr), 64'(DEPTH));
        chk("t1_status", 64'(status_out), 64'h8000_0200);
        repeat (5) step();
        chk("t1_we_after", 64'(bram_we), 64'h0);
        din_inc = 1'b0;

        // 2: external trigger after a long wait
        ctrl_in = 32'h0;
        step();
        n_wr    = 0;
        ctrl_in = 32'h1;
        step();
        ctrl_in = 32'h0;
        repeat (50) step();
        chk("t2_armed", 64'(status_out), 64'h4000_0000);
        chk("t2_no_we", 64'(n_wr), 64'h0);
        trig_in = 1'b1;
        step();
        trig_in = 1'b0;
        wait_status(32'h8000_0000, 32'h8000_0000, 600, "t2_done");
        chk("t2_writes", 64'(n_wr), 64'(DEPTH));
        chk("t2_status", 64'(status_out), 64'h8000_0200);

        // 3: qualifier toggling every cycle
        n_wr    = 0;
        ctrl_in = 32'h7;
        step();
        ctrl_in = 32'h6;
        cyc     = 0;
        while (!status_out[31] && cyc < 3000) begin
            we_in = ~we_in;
            step();
            cyc++;
        end
        we_in = 1'b0;
        chk("t3_done", 64'(status_out[31]), 64'h1);
        chk("t3_writes", 64'(n_wr), 64'(DEPTH));
        chk("t3_span", 64'(cyc >= 1015 && cyc <= 1035), 64'h1);

        // 4: arm held high through completion, then a fresh edge
        ctrl_in = 32'h0;
        step();
        ctrl_in = 32'h3;
        step();
        wait_status(32'h8000_0000, 32'h8000_0000, 600, "t4_done");
        n_wr = 0;
        repeat (100) step();
        chk("t4_no_rearm", 64'(n_wr), 64'h0);
        chk("t4_hold_status", 64'(status_out), 64'h8000_0200);
        ctrl_in = 32'h2;
        step();
        ctrl_in = 32'h3;
        step();
        chk("t4_rearm_status", 64'(status_out), 64'h4000_0000);
        wait_status(32'h8000_0000, 32'h8000_0000, 600, "t4_done2");
        chk("t4_writes", 64'(n_wr), 64'(DEPTH));

        // 5: re-arm at wr_count 100
        ctrl_in = 32'h0;
        step();
        ctrl_in = 32'h3;
        step();
        ctrl_in = 32'h2;
        wait_status(32'h0000_03FF, 32'd100, 200, "t5_reach100");
        ctrl_in = 32'h1;
        step();
        chk("t5_rearm_status", 64'(status_out), 64'h4000_0000);
        chk("t5_rearm_we", 64'(bram_we), 64'h0);
        ctrl_in = 32'h0;
        repeat (10) step();
        chk("t5_still_armed", 64'(status_out), 64'h4000_0000);
        n_wr    = 0;
        trig_in = 1'b1;
        step();
        trig_in = 1'b0;
        wait_status(32'h8000_0000, 32'h8000_0000, 600, "t5_done");
        chk("t5_writes", 64'(n_wr), 64'(DEPTH));

        // 6: asynchronous reset at wr_count 300
        ctrl_in = 32'h3;
        step();
        ctrl_in = 32'h2;
        wait_status(32'h0000_03FF, 32'd300, 400, "t6_reach300");
        #3;
        OPB_Rst = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_we", 64'(bram_we), 64'h0);
        chk("t6_rst_addr", 64'(bram_addr), 64'h0);
        chk("t6_rst_data", 64'(bram_data), 64'h0);
        chk("t6_rst_status", 64'(status_out), 64'h0);
        ctrl_in = 32'h0;
        repeat (3) step();
        OPB_Rst = 1'b0;
        n_wr    = 0;
        ctrl_in = 32'h2;
        trig_in = 1'b1;
        repeat (30) step();
        trig_in = 1'b0;
        chk("t6_quiet_writes", 64'(n_wr), 64'h0);
        chk("t6_quiet_status", 64'(status_out), 64'h0);
        ctrl_in = 32'h3;
        step();
        chk("t6_fresh_arm", 64'(status_out), 64'h4000_0000);

        // random traffic, model checks every cycle
        for (int k = 0; k < 3000; k++) begin
            ctrl_in[31:1] = 31'($urandom);
            if ($urandom_range(0, 199) == 0) ctrl_in[0] = ~ctrl_in[0];
            trig_in = ($urandom_range(0, 19) == 0);
            we_in   = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
